// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
// Parity modes, serializer states and frame width live here.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} tx_state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic calcParity(input logic [UART_DATA_BITS-1:0] d, input parity_e p);
    return (p == PAR_ODD) ? ~(^d) : ^d;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with wrap-bit pointers and registered full/empty/level flags.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wrData,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdData,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic [AW:0]      r_level;
  logic             r_full;
  logic             r_empty;
  logic [AW:0]      w_wrPtrNext;
  logic [AW:0]      w_rdPtrNext;
  logic             w_doPush;
  logic             w_doPop;

  assign w_doPush    = i_push && !r_full;
  assign w_doPop     = i_pop && !r_empty;
  assign w_wrPtrNext = w_doPush ? r_wrPtr + PTR_ONE : r_wrPtr;
  assign w_rdPtrNext = w_doPop  ? r_rdPtr + PTR_ONE : r_rdPtr;

  // Flags come from the next pointers so they are valid right after each edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wrPtr <= w_wrPtrNext;
      r_rdPtr <= w_rdPtrNext;
      r_level <= w_wrPtrNext - w_rdPtrNext;
      r_full  <= (w_wrPtrNext[AW] != w_rdPtrNext[AW]) &&
                 (w_wrPtrNext[AW-1:0] == w_rdPtrNext[AW-1:0]);
      r_empty <= (w_wrPtrNext == w_rdPtrNext);
    end
  end

  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= i_wrData;
  end

  assign o_rdData = r_mem[r_rdPtr[AW-1:0]];
  assign o_full   = r_full;
  assign o_empty  = r_empty;
  assign o_level  = r_level;

endmodule

// File: rtl/uart_buffered_tx.sv
// Buffered UART transmitter: FIFO front end feeding a serializer FSM.
// tx is registered one cycle behind the FSM state, so frames start two edges after acceptance.
module uart_buffered_tx import uart_pkg::*; #(
  parameter int      PRESCALER = 48,
  parameter int      DEPTH     = 16,
  parameter parity_e PARITY    = PAR_NONE,
  parameter int      STOP_BITS = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [UART_DATA_BITS-1:0]     data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(DEPTH):0]        level
);

  localparam int BAUD_W = $clog2(PRESCALER);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(PRESCALER - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = {{(BAUD_W-1){1'b0}}, 1'b1};

  tx_state_e                 r_state;
  logic [BAUD_W-1:0]         r_baudCnt;
  logic [2:0]                r_bitIdx;
  logic                      r_stopIdx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic                      r_parity;
  logic                      r_tx;
  logic                      r_busy;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_baudLast;
  logic                      w_lastStop;
  logic [UART_DATA_BITS-1:0] w_rdData;

  assign w_push     = valid && ready;
  assign w_baudLast = (r_baudCnt == BAUD_LAST);
  assign w_lastStop = (STOP_BITS == 1) || r_stopIdx;
  assign w_pop      = !w_empty && ((r_state == ST_IDLE) ||
                                   (r_state == ST_STOP && w_baudLast && w_lastStop));

  uart_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_push   (w_push),
    .i_wrData (data),
    .i_pop    (w_pop),
    .o_rdData (w_rdData),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_level  (level)
  );

  // Each state drives tx for its own duration; a pop loads shift reg and parity together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_baudCnt <= '0;
      r_bitIdx  <= '0;
      r_stopIdx <= 1'b0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= w_push || !w_empty || (r_state != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_pop) begin
            r_shift   <= w_rdData;
            r_parity  <= calcParity(w_rdData, PARITY);
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_tx <= 1'b0;
          if (w_baudLast) begin
            r_baudCnt <= '0;
            r_state   <= ST_DATA;
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        ST_DATA: begin
          r_tx <= r_shift[0];
          if (w_baudLast) begin
            r_baudCnt <= '0;
            r_shift   <= r_shift >> 1;
            if (r_bitIdx == 3'd7) begin
              r_stopIdx <= 1'b0;
              r_state   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              r_bitIdx <= r_bitIdx + 3'd1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        ST_PARITY: begin
          r_tx <= r_parity;
          if (w_baudLast) begin
            r_baudCnt <= '0;
            r_stopIdx <= 1'b0;
            r_state   <= ST_STOP;
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        ST_STOP: begin
          r_tx <= 1'b1;
          if (w_baudLast) begin
            r_baudCnt <= '0;
            if (w_lastStop) begin
              r_stopIdx <= 1'b0;
              if (w_pop) begin
                r_shift  <= w_rdData;
                r_parity <= calcParity(w_rdData, PARITY);
                r_bitIdx <= '0;
                r_state  <= ST_START;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_stopIdx <= 1'b1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + BAUD_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ready = !w_full;
  assign tx    = r_tx;
  assign busy  = r_busy;

endmodule

// File: tb/tb_uart_buffered_tx.sv
// Self-checking bench: three parity/stop configurations run side by side against a
// cycle-level line model built from frame timing rules, with random and directed traffic.
module tb_uart_buffered_tx;
  import uart_pkg::*;

  localparam int PRESC = 4;
  localparam int DEPTH = 16;
  localparam int MAXC  = 12000;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam parity_e CPAR  = (g == 0) ? PAR_NONE : ((g == 1) ? PAR_EVEN : PAR_ODD);
    localparam int      CSTOP = (g == 2) ? 2 : 1;
    localparam int      NBITS = 10 + ((CPAR != PAR_NONE) ? 1 : 0) + CSTOP - 1;
    localparam int      FLEN  = NBITS * PRESC;

    logic          reset_n = 1'b1;
    logic          valid   = 1'b0;
    logic [7:0]    data    = 8'h00;
    logic          ready;
    logic          tx;
    logic          busy;
    logic [LW-1:0] level;
    bit            done = 1'b0;

    // Model state: expected low periods on the line, busy windows and FIFO level steps.
    bit expLow  [MAXC];
    bit expBusy [MAXC];
    int levelDelta [MAXC];
    int cycCount = 0;
    int expLevel = 0;
    int lineFree = 0;

    uart_buffered_tx #(
      .PRESCALER (PRESC),
      .DEPTH     (DEPTH),
      .PARITY    (CPAR),
      .STOP_BITS (CSTOP)
    ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data),
      .valid   (valid),
      .ready   (ready),
      .tx      (tx),
      .busy    (busy),
      .level   (level)
    );

    function automatic bit frameBit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && CPAR == PAR_EVEN) return ^b;
      if (k == 9 && CPAR == PAR_ODD)  return ~(^b);
      return 1'b1;
    endfunction

    // A frame starts when the line is free, but never sooner than two edges after acceptance.
    task automatic scheduleFrame(input int a, input logic [7:0] b);
      int start;
      start = (lineFree > a + 2) ? lineFree : a + 2;
      for (int k = 0; k < NBITS; k++)
        for (int p = 0; p < PRESC; p++)
          if (start + k * PRESC + p < MAXC) expLow[start + k * PRESC + p] = !frameBit(b, k);
      for (int i = a; i < start + FLEN; i++)
        if (i < MAXC) expBusy[i] = 1'b1;
      if (a < MAXC) levelDelta[a] += 1;
      if (start - 1 < MAXC) levelDelta[start - 1] -= 1;
      lineFree = start + FLEN;
    endtask

    initial begin
      forever begin
        int c;
        @(posedge clk);
        c = cycCount;
        cycCount++;
        if (reset_n && valid && expLevel < DEPTH) scheduleFrame(c, data);
        if (c < MAXC) expLevel += levelDelta[c];
        #1;
        if (c < MAXC) begin
          checkOutput($sformatf("cfg%0d tx c%0d", g, c), int'(tx), int'(!expLow[c]));
          checkOutput($sformatf("cfg%0d busy c%0d", g, c), int'(busy), int'(expBusy[c]));
          checkOutput($sformatf("cfg%0d level c%0d", g, c), int'(level), expLevel);
          checkOutput($sformatf("cfg%0d ready c%0d", g, c), int'(ready), int'(expLevel < DEPTH));
        end
      end
    end

    task automatic applyStimulus(input logic [7:0] b);
      int  waited;
      logic sampled;
      waited = 0;
      @(negedge clk);
      valid = 1'b1;
      data  = b;
      forever begin
        sampled = ready;
        @(posedge clk);
        if (sampled) break;
        @(negedge clk);
        waited++;
        if (waited > 3000) begin
          checkOutput($sformatf("cfg%0d accept timeout", g), waited, 0);
          break;
        end
      end
    endtask

    task automatic dropValid();
      @(negedge clk);
      valid = 1'b0;
    endtask

    task automatic waitIdle();
      int guard;
      guard = 0;
      dropValid();
      while (cycCount < lineFree + 2 && guard < 5000) begin
        @(negedge clk);
        guard++;
      end
      checkOutput($sformatf("cfg%0d idle timeout", g), int'(guard >= 5000), 0);
      checkOutput($sformatf("cfg%0d idle busy", g), int'(busy), 0);
      checkOutput($sformatf("cfg%0d idle tx", g), int'(tx), 1);
    endtask

    // Asserting reset mid-cycle must force the line idle and flush everything at once.
    task automatic applyReset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput($sformatf("cfg%0d rst tx", g), int'(tx), 1);
      checkOutput($sformatf("cfg%0d rst level", g), int'(level), 0);
      checkOutput($sformatf("cfg%0d rst ready", g), int'(ready), 1);
      checkOutput($sformatf("cfg%0d rst busy", g), int'(busy), 0);
      for (int i = cycCount; i < MAXC; i++) begin
        expLow[i]     = 1'b0;
        expBusy[i]    = 1'b0;
        levelDelta[i] = 0;
      end
      expLevel = 0;
      lineFree = 0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
    endtask

    initial begin
      int gap;
      #1 reset_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(posedge clk);

      applyStimulus((g == 0) ? 8'h55 : 8'h07);
      waitIdle();

      for (int i = 0; i < 17; i++) applyStimulus(8'(i));
      waitIdle();

      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      dropValid();
      repeat (PRESC + 6) @(posedge clk);
      applyReset();
      repeat (20) @(posedge clk);

      applyStimulus(8'hFF);
      for (int n = 0; n < 40; n++) begin
        gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 2 * FLEN);
        if (gap > 0) begin
          dropValid();
          repeat (gap - 1) @(posedge clk);
        end
        applyStimulus(8'($urandom));
      end
      waitIdle();
      done = 1'b1;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(cfg[0].done && cfg[1].done && cfg[2].done) && guard < 30000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("all configs finished", int'(guard < 30000), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
